// File: rtl/rm_c4lw_violation_collector_pkg.sv
// Shared types and constants for the cluster-4 load-word violation collector.
// Report entries carry the masked hit vector, the originating symbol and its cycle stamp.
package rm_monitor_pkg;

    localparam int NUM_LTL = 9;
    localparam int SYM_W   = 8;
    localparam int CYC_W   = 32;
    localparam int CNT_W   = 16;

    typedef logic [NUM_LTL-1:0] ltl_vec_t;

    typedef struct packed {
        ltl_vec_t           mask;
        logic [SYM_W-1:0]   symbol;
        logic [CYC_W-1:0]   cycle;
    } rm_report_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/rm_c4lw_violation_collector_fifo.sv
// Report FIFO with first-word-fall-through head and synchronous flush.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module rm_report_fifo
    import rm_monitor_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        push,
    input  rm_report_t  push_data,
    input  logic        pop,
    output rm_report_t  head,
    output logic        full,
    output logic        empty,
    output logic        push_ok,
    output logic        pop_ok
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rm_report_t      mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;

    assign full    = (count_r == (AW+1)'(DEPTH));
    assign empty   = (count_r == (AW+1)'(0));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem_r[rd_ptr_r];

    // Storage array; contents are don't-care while not counted as occupied.
    always_ff @(posedge clk) begin
        if (push_ok && !flush && !reset) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rm_c4lw_violation_collector.sv
// Collects LTL monitor hit flags: sticky status, saturating counters, time-stamped
// report FIFO with drop accounting, and a registered level interrupt.
module rm_c4lw_violation_collector
    import rm_monitor_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int HIT_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    input  logic [SYM_W-1:0]          symbols,
    input  logic [NUM_LTL-1:0]        ltl_hits,
    input  logic [NUM_LTL-1:0]        en_mask,
    input  logic [NUM_LTL-1:0]        irq_mask,
    input  logic                      clear,
    output logic [NUM_LTL-1:0]        sticky,
    output logic [NUM_LTL*CNT_W-1:0]  hit_cnt,
    output logic                      rpt_valid,
    input  logic                      rpt_ready,
    output logic [NUM_LTL-1:0]        rpt_mask,
    output logic [SYM_W-1:0]          rpt_symbol,
    output logic [CYC_W-1:0]          rpt_cycle,
    output logic                      overflow,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic                      irq
);

    logic [CYC_W-1:0]  cyc_r;
    logic              run_d_s;
    logic [SYM_W-1:0]  sym_d_s;
    logic [CYC_W-1:0]  cyc_d_s;
    ltl_vec_t          hv_s;
    ltl_vec_t          sticky_r;
    logic [CNT_W-1:0]  cnt_r [NUM_LTL];
    logic              overflow_r;
    logic [CNT_W-1:0]  drop_cnt_r;
    logic              irq_r;
    rm_report_t        head_s;
    logic              full_s;
    logic              empty_s;
    logic              push_ok_s;
    logic              pop_ok_s;
    logic              push_s;

    // Free-running stamp of valid symbols; clear deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_r <= '0;
        end else if (run) begin
            cyc_r <= cyc_r + {{(CYC_W-1){1'b0}}, 1'b1};
        end else begin
            cyc_r <= cyc_r;
        end
    end

    generate
        if (HIT_LAT == 0) begin : g_no_delay
            assign run_d_s = run;
            assign sym_d_s = symbols;
            assign cyc_d_s = cyc_r;
        end else begin : g_delay
            logic [HIT_LAT-1:0] run_pipe_r;
            logic [SYM_W-1:0]   sym_pipe_r [HIT_LAT];
            logic [CYC_W-1:0]   cyc_pipe_r [HIT_LAT];

            // Align the symbol context with the monitor's hit latency.
            always_ff @(posedge clk) begin
                if (reset) begin
                    run_pipe_r <= '0;
                    for (int i = 0; i < HIT_LAT; i++) begin
                        sym_pipe_r[i] <= '0;
                        cyc_pipe_r[i] <= '0;
                    end
                end else begin
                    run_pipe_r[0] <= run;
                    sym_pipe_r[0] <= symbols;
                    cyc_pipe_r[0] <= cyc_r;
                    for (int i = 1; i < HIT_LAT; i++) begin
                        run_pipe_r[i] <= run_pipe_r[i-1];
                        sym_pipe_r[i] <= sym_pipe_r[i-1];
                        cyc_pipe_r[i] <= cyc_pipe_r[i-1];
                    end
                end
            end

            assign run_d_s = run_pipe_r[HIT_LAT-1];
            assign sym_d_s = sym_pipe_r[HIT_LAT-1];
            assign cyc_d_s = cyc_pipe_r[HIT_LAT-1];
        end
    endgenerate

    assign hv_s   = ltl_hits & en_mask & {NUM_LTL{run_d_s}};
    assign push_s = |hv_s;

    // Sticky status and per-property saturating counters.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sticky_r <= '0;
            for (int i = 0; i < NUM_LTL; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            sticky_r <= sticky_r | hv_s;
            for (int i = 0; i < NUM_LTL; i++) begin
                if (hv_s[i]) begin
                    cnt_r[i] <= sat_inc(cnt_r[i]);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    rm_report_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (clear),
        .push      (push_s),
        .push_data ('{mask: hv_s, symbol: sym_d_s, cycle: cyc_d_s}),
        .pop       (rpt_ready),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .push_ok   (push_ok_s),
        .pop_ok    (pop_ok_s)
    );

    // Drop accounting for pushes refused by a full FIFO.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= '0;
        end else if (push_s && !push_ok_s) begin
            overflow_r <= 1'b1;
            drop_cnt_r <= sat_inc(drop_cnt_r);
        end else begin
            overflow_r <= overflow_r;
            drop_cnt_r <= drop_cnt_r;
        end
    end

    // Interrupt follows the registered status by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= (|(sticky_r & irq_mask)) | overflow_r;
        end
    end

    generate
        for (genvar g = 0; g < NUM_LTL; g++) begin : g_cnt_out
            assign hit_cnt[g*CNT_W +: CNT_W] = cnt_r[g];
        end
    endgenerate

    assign sticky     = sticky_r;
    assign overflow   = overflow_r;
    assign drop_cnt   = drop_cnt_r;
    assign irq        = irq_r;
    assign rpt_valid  = !empty_s;
    assign rpt_mask   = empty_s ? '0 : head_s.mask;
    assign rpt_symbol = empty_s ? '0 : head_s.symbol;
    assign rpt_cycle  = empty_s ? '0 : head_s.cycle;

endmodule

// File: tb/tb_rm_c4lw_violation_collector.sv
// Directed and random checks of the violation collector against a queue-based reference model.
module tb_rm_c4lw_violation_collector;
    import rm_monitor_pkg::*;

    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset, run, clear, rpt_ready;
    logic [7:0]   symbols;
    logic [8:0]   ltl_hits, en_mask, irq_mask;
    logic [8:0]   sticky, rpt_mask;
    logic [143:0] hit_cnt;
    logic         rpt_valid, overflow, irq;
    logic [7:0]   rpt_symbol;
    logic [31:0]  rpt_cycle;
    logic [15:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rm_c4lw_violation_collector #(.DEPTH(D), .HIT_LAT(1)) dut (
        .clk(clk), .reset(reset), .run(run), .symbols(symbols), .ltl_hits(ltl_hits),
        .en_mask(en_mask), .irq_mask(irq_mask), .clear(clear), .sticky(sticky),
        .hit_cnt(hit_cnt), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_mask(rpt_mask), .rpt_symbol(rpt_symbol), .rpt_cycle(rpt_cycle),
        .overflow(overflow), .drop_cnt(drop_cnt), .irq(irq)
    );

    typedef struct { logic run; logic [7:0] sym; logic [31:0] cyc; } stage_t;
    typedef struct { logic [8:0] m; logic [7:0] s; logic [31:0] c; } rep_t;

    stage_t      pipe[$];
    rep_t        q[$];
    logic [31:0] m_cyc;
    logic [8:0]  m_sticky;
    int          m_cnt[9];
    logic        m_ovf;
    int          m_drops;
    logic        m_irq;

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        stage_t z;
        z.run = 1'b0; z.sym = 8'h00; z.cyc = 32'h0;
        q.delete();
        pipe.delete();
        pipe.push_back(z);
        m_cyc = 32'h0; m_sticky = 9'h000; m_ovf = 1'b0; m_drops = 0; m_irq = 1'b0;
        for (int i = 0; i < 9; i++) m_cnt[i] = 0;
    endtask

    // Next state of the reference, from the inputs the DUT is about to sample.
    task automatic model_step();
        stage_t d, n;
        rep_t   r;
        logic [8:0] hv;
        logic do_pop, irq_n;
        d      = pipe[0];
        hv     = ltl_hits & en_mask & (d.run ? 9'h1FF : 9'h000);
        do_pop = (q.size() > 0) && rpt_ready;
        irq_n  = (|(m_sticky & irq_mask)) || m_ovf;
        if (reset) begin
            model_reset();
        end else begin
            n.run = run; n.sym = symbols; n.cyc = m_cyc;
            void'(pipe.pop_front());
            pipe.push_back(n);
            if (run) m_cyc = m_cyc + 32'd1;
            if (clear) begin
                q.delete();
                m_sticky = 9'h000; m_ovf = 1'b0; m_drops = 0;
                for (int i = 0; i < 9; i++) m_cnt[i] = 0;
            end else begin
                m_sticky = m_sticky | hv;
                for (int i = 0; i < 9; i++)
                    if (hv[i] && m_cnt[i] < 65535) m_cnt[i]++;
                if (do_pop) void'(q.pop_front());
                if (hv != 9'h000) begin
                    if (q.size() < D) begin
                        r.m = hv; r.s = d.sym; r.c = d.cyc;
                        q.push_back(r);
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drops < 65535) m_drops++;
                    end
                end
            end
            m_irq = irq_n;
        end
    endtask

    task automatic check_all();
        logic [143:0] e;
        for (int i = 0; i < 9; i++) e[i*16 +: 16] = 16'(m_cnt[i]);
        chk("sticky", 144'(sticky), 144'(m_sticky));
        chk("hit_cnt", hit_cnt, e);
        chk("overflow", 144'(overflow), 144'(m_ovf));
        chk("drop_cnt", 144'(drop_cnt), 144'(16'(m_drops)));
        chk("irq", 144'(irq), 144'(m_irq));
        chk("rpt_valid", 144'(rpt_valid), 144'(q.size() > 0));
        if (q.size() > 0) begin
            chk("rpt_mask", 144'(rpt_mask), 144'(q[0].m));
            chk("rpt_symbol", 144'(rpt_symbol), 144'(q[0].s));
            chk("rpt_cycle", 144'(rpt_cycle), 144'(q[0].c));
        end
    endtask

    task automatic tick(input bit do_check = 1'b1);
        model_step();
        @(posedge clk);
        #1;
        if (do_check) check_all();
    endtask

    initial begin
        int n_valid;
        reset = 1'b1; run = 1'b0; clear = 1'b0; rpt_ready = 1'b0;
        symbols = 8'h00; ltl_hits = 9'h000; en_mask = 9'h1FF; irq_mask = 9'h000;
        model_reset();
        tick(); tick();
        chk("rst_sticky", 144'(sticky), 144'(9'h000));
        chk("rst_hit_cnt", hit_cnt, 144'h0);
        chk("rst_valid", 144'(rpt_valid), 144'(1'b0));
        chk("rst_rpt", 144'({rpt_mask, rpt_symbol, rpt_cycle}), 144'h0);
        chk("rst_ovf_drop", 144'({overflow, drop_cnt}), 144'h0);
        chk("rst_irq", 144'(irq), 144'(1'b0));

        // Basic hit: symbol 0x3C stamped 10, hit flag one cycle later
        reset = 1'b0; run = 1'b1; irq_mask = 9'h004;
        for (int i = 0; i < 10; i++) begin symbols = 8'($urandom); tick(); end
        symbols = 8'h3C; tick();
        symbols = 8'h00; ltl_hits = 9'h004; tick();
        chk("hit_mask", 144'(rpt_mask), 144'(9'h004));
        chk("hit_sym", 144'(rpt_symbol), 144'(8'h3C));
        chk("hit_cyc", 144'(rpt_cycle), 144'(32'd10));
        chk("hit_sticky", 144'(sticky), 144'(9'h004));
        chk("hit_cnt2", 144'(hit_cnt[47:32]), 144'(16'd1));
        chk("irq_early", 144'(irq), 144'(1'b0));
        ltl_hits = 9'h000; tick();
        chk("irq_late", 144'(irq), 144'(1'b1));
        rpt_ready = 1'b1; tick(); rpt_ready = 1'b0;

        // Unqualified hits: delayed run low, then property disabled
        run = 1'b0; tick();
        run = 1'b1; ltl_hits = 9'h1FF; tick();
        chk("nrun_valid", 144'(rpt_valid), 144'(1'b0));
        en_mask = 9'h000; ltl_hits = 9'h008; tick();
        chk("dis_sticky", 144'(sticky), 144'(9'h004));
        chk("dis_cnt3", 144'(hit_cnt[63:48]), 144'(16'd0));
        en_mask = 9'h1FF; ltl_hits = 9'h000; tick();

        // Overflow with irq driven only by overflow
        irq_mask = 9'h000; tick(); tick();
        for (int i = 0; i < 5; i++) begin symbols = 8'(8'h50 + i); ltl_hits = 9'h0A1; tick(); end
        ltl_hits = 9'h000; tick();
        chk("ovf", 144'(overflow), 144'(1'b1));
        chk("drop1", 144'(drop_cnt), 144'(16'd1));
        tick();
        chk("ovf_irq", 144'(irq), 144'(1'b1));

        // Full FIFO: simultaneous push and pop, then drain and count occupancy
        rpt_ready = 1'b1; ltl_hits = 9'h100; symbols = 8'h77; tick();
        chk("fullpp_drop", 144'(drop_cnt), 144'(16'd1));
        ltl_hits = 9'h000;
        n_valid = 0;
        for (int i = 0; i < 10; i++) begin
            if (rpt_valid) n_valid++;
            tick();
        end
        chk("occupancy", 144'(n_valid), 144'(D));

        // Clear has priority over a same-cycle hit
        rpt_ready = 1'b0; ltl_hits = 9'h001; tick(); tick();
        clear = 1'b1; tick(); clear = 1'b0; ltl_hits = 9'h000;
        chk("clr_sticky", 144'(sticky), 144'(9'h000));
        chk("clr_cnt", hit_cnt, 144'h0);
        chk("clr_ovf", 144'(overflow), 144'(1'b0));
        chk("clr_valid", 144'(rpt_valid), 144'(1'b0));
        tick();

        // Saturate counter 0
        rpt_ready = 1'b1; ltl_hits = 9'h001;
        for (int i = 0; i < 65540; i++) tick(1'b0);
        tick();
        chk("sat_cnt0", 144'(hit_cnt[15:0]), 144'(16'hFFFF));
        tick();
        chk("sat_hold", 144'(hit_cnt[15:0]), 144'(16'hFFFF));

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            run       = ($urandom_range(0, 3) != 0);
            symbols   = 8'($urandom);
            ltl_hits  = ($urandom_range(0, 2) == 0) ? 9'($urandom) : 9'h000;
            if ($urandom_range(0, 30) == 0) en_mask = 9'($urandom);
            if ($urandom_range(0, 30) == 0) en_mask = 9'h1FF;
            if ($urandom_range(0, 20) == 0) irq_mask = 9'($urandom);
            rpt_ready = ($urandom_range(0, 2) == 0);
            clear     = ($urandom_range(0, 60) == 0);
            reset     = ($urandom_range(0, 200) == 0);
            tick();
        end
        reset = 1'b0; clear = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
